// File: rtl/bank_xbar_rtn_buf_pkg.sv
// -----------------------------------------------------------------------------
// bank_pkg
// Shared constants and types for the bank xbar return buffer.
//   CH_NUM / CH_W : number of xbar channels and channel_id width
//   ROB_W         : requester ROB tag width
//   DATA_W        : return data width
//   xbar_rtn_beat_t : one buffered return beat {rob_num, data}
// -----------------------------------------------------------------------------
package bank_pkg;

    localparam int CH_W   = 2;
    localparam int CH_NUM = 1 << CH_W;
    localparam int ROB_W  = 3;
    localparam int DATA_W = 128;

    typedef logic [CH_W-1:0]  chan_id_t;
    typedef logic [ROB_W-1:0] rob_num_t;

    typedef struct packed {
        rob_num_t            rob_num;
        logic [DATA_W-1:0]   data;
    } xbar_rtn_beat_t;

    localparam int BEAT_W = $bits(xbar_rtn_beat_t);

endpackage

// File: rtl/bank_xbar_rtn_buf_if.sv
// -----------------------------------------------------------------------------
// bank_xbar_rtn_buf_if
// Handshake bundle around the return buffer.
//   sc_xbar_*   : single return stream from the SRAM controller (valid/ready)
//   xbar_rtn_*  : per-channel return ports toward the crossbar, packed
//                 channel c at [c*ROB_W +: ROB_W] / [c*DATA_W +: DATA_W]
// modport master : the environment (SRAM controller + crossbar side)
// modport slave  : the return buffer
// -----------------------------------------------------------------------------
interface bank_xbar_rtn_buf_if;
    import bank_pkg::*;

    logic                       sc_xbar_valid_i;
    logic                       sc_xbar_ready_o;
    chan_id_t                   sc_xbar_channel_id_i;
    rob_num_t                   sc_xbar_rob_num_i;
    logic [DATA_W-1:0]          sc_xbar_data_i;

    logic [CH_NUM-1:0]          xbar_rtn_valid_o;
    logic [CH_NUM-1:0]          xbar_rtn_ready_i;
    logic [CH_NUM*ROB_W-1:0]    xbar_rtn_rob_num_o;
    logic [CH_NUM*DATA_W-1:0]   xbar_rtn_data_o;

    modport master (
        output sc_xbar_valid_i,
        input  sc_xbar_ready_o,
        output sc_xbar_channel_id_i,
        output sc_xbar_rob_num_i,
        output sc_xbar_data_i,
        input  xbar_rtn_valid_o,
        output xbar_rtn_ready_i,
        input  xbar_rtn_rob_num_o,
        input  xbar_rtn_data_o
    );

    modport slave (
        input  sc_xbar_valid_i,
        output sc_xbar_ready_o,
        input  sc_xbar_channel_id_i,
        input  sc_xbar_rob_num_i,
        input  sc_xbar_data_i,
        output xbar_rtn_valid_o,
        input  xbar_rtn_ready_i,
        output xbar_rtn_rob_num_o,
        output xbar_rtn_data_o
    );

endinterface

// File: rtl/bank_xbar_rtn_buf_fifo.sv
// -----------------------------------------------------------------------------
// bank_rtn_fifo
// Synchronous FIFO, one per xbar channel. Storage is not reset; only the
// pointers and the occupancy count are.
//   clk_i, rst_i : clock, synchronous active-high reset
//   i_push, i_data, o_full : write side (push ignored when full)
//   i_pop, o_empty, o_head : read side, head shown combinationally
//   o_count      : occupancy 0..DEPTH
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module bank_rtn_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    input  logic             i_pop,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    // Full is judged before any same-cycle pop: no write-through when full.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push && !rst_i) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/bank_xbar_rtn_buf.sv
// -----------------------------------------------------------------------------
// bank_xbar_rtn_buf
// Return buffer behind the SRAM controller xbar return port. Beats are
// steered by channel_id into per-channel FIFOs so a stalled crossbar channel
// never blocks returns headed to the other channels.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   bus (slave)    : sc_xbar_* input stream and per-channel xbar_rtn_* ports
//   xbar_rtn_cnt_o : packed per-channel occupancy (debug/perf)
//   rob_err_o      : sticky per-channel ROB order error
// Optional build macro BANK_XBAR_RTN_ROB_CHK_EN enables the in-order ROB
// tag checker; without it rob_err_o is tied low. Port list is identical.
// -----------------------------------------------------------------------------
module bank_xbar_rtn_buf
    import bank_pkg::*;
#(
    parameter  int FIFO_DEPTH = 2,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    bank_xbar_rtn_buf_if.slave       bus,
    output logic [CH_NUM*CNT_W-1:0]  xbar_rtn_cnt_o,
    output logic [CH_NUM-1:0]        rob_err_o
);

    xbar_rtn_beat_t     w_in_beat;
    xbar_rtn_beat_t     w_head  [CH_NUM];
    logic               w_full  [CH_NUM];
    logic               w_empty [CH_NUM];
    logic [CNT_W-1:0]   w_cnt   [CH_NUM];
    logic [CH_NUM-1:0]  w_push;
    logic [CH_NUM-1:0]  w_pop;
    logic               w_accept;

    assign w_in_beat = '{rob_num: bus.sc_xbar_rob_num_i, data: bus.sc_xbar_data_i};

    // Ready follows the addressed channel only; upstream holds payload stable.
    assign bus.sc_xbar_ready_o = !w_full[bus.sc_xbar_channel_id_i];
    assign w_accept            = bus.sc_xbar_valid_i && bus.sc_xbar_ready_o;

    always_comb begin
        w_push = '0;
        w_pop  = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            w_push[c] = w_accept && (bus.sc_xbar_channel_id_i == CH_W'(c));
            w_pop[c]  = !w_empty[c] && bus.xbar_rtn_ready_i[c];
        end
    end

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        bank_rtn_fifo #(
            .WIDTH (BEAT_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .i_push  (w_push[c]),
            .i_data  (w_in_beat),
            .o_full  (w_full[c]),
            .i_pop   (w_pop[c]),
            .o_empty (w_empty[c]),
            .o_head  (w_head[c]),
            .o_count (w_cnt[c])
        );
    end

    always_comb begin
        bus.xbar_rtn_valid_o   = '0;
        bus.xbar_rtn_rob_num_o = '0;
        bus.xbar_rtn_data_o    = '0;
        xbar_rtn_cnt_o         = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            bus.xbar_rtn_valid_o[c]                  = !w_empty[c];
            bus.xbar_rtn_rob_num_o[c*ROB_W +: ROB_W] = w_head[c].rob_num;
            bus.xbar_rtn_data_o[c*DATA_W +: DATA_W]  = w_head[c].data;
            xbar_rtn_cnt_o[c*CNT_W +: CNT_W]         = w_cnt[c];
        end
    end

`ifdef BANK_XBAR_RTN_ROB_CHK_EN
    rob_num_t           r_exp_rob [CH_NUM];
    logic [CH_NUM-1:0]  r_rob_err;

    // Expected tag resyncs to the received tag + 1 even after a mismatch,
    // so one dropped tag flags once instead of on every later beat.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < CH_NUM; c++) r_exp_rob[c] <= '0;
            r_rob_err <= '0;
        end else begin
            for (int c = 0; c < CH_NUM; c++) begin
                if (w_push[c]) begin
                    if (bus.sc_xbar_rob_num_i != r_exp_rob[c]) r_rob_err[c] <= 1'b1;
                    r_exp_rob[c] <= bus.sc_xbar_rob_num_i + ROB_W'(1);
                end
            end
        end
    end

    assign rob_err_o = r_rob_err;
`else
    assign rob_err_o = '0;
`endif

endmodule

// File: tb/tb_bank_xbar_rtn_buf.sv
module tb_bank_xbar_rtn_buf;
    import bank_pkg::*;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bank_xbar_rtn_buf_if bus ();
    logic [CH_NUM*CW-1:0] cnt;
    logic [CH_NUM-1:0]    err;

    bank_xbar_rtn_buf #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .bus            (bus),
        .xbar_rtn_cnt_o (cnt),
        .rob_err_o      (err)
    );

    // ---------------- reference model: one queue per channel ----------------
    typedef struct packed {
        rob_num_t          rob;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t              q [CH_NUM][$];
    rob_num_t          m_exp [CH_NUM];
    logic [CH_NUM-1:0] m_err;
    bit                model_ok = 1'b0;
    rob_num_t          ch1_out [$];

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [DATA_W-1:0] act,
                                input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic drive(input bit r, input bit v, input int ch, input rob_num_t rob,
                         input logic [DATA_W-1:0] d, input logic [CH_NUM-1:0] rdy);
        rst                      = r;
        bus.sc_xbar_valid_i      = v;
        bus.sc_xbar_channel_id_i = chan_id_t'(ch);
        bus.sc_xbar_rob_num_i    = rob;
        bus.sc_xbar_data_i       = d;
        bus.xbar_rtn_ready_i     = rdy;
    endtask

    function automatic void check_model();
        int ch;
        if (!model_ok) return;
        ch = int'(bus.sc_xbar_channel_id_i);
        chk("sc_ready", DATA_W'(bus.sc_xbar_ready_o), DATA_W'(q[ch].size() < DEPTH));
        for (int c = 0; c < CH_NUM; c++) begin
            chk($sformatf("valid[%0d]", c), DATA_W'(bus.xbar_rtn_valid_o[c]),
                DATA_W'(q[c].size() != 0));
            chk($sformatf("cnt[%0d]", c), DATA_W'(cnt[c*CW +: CW]), DATA_W'(q[c].size()));
            if (q[c].size() != 0) begin
                chk($sformatf("rob[%0d]", c), DATA_W'(bus.xbar_rtn_rob_num_o[c*ROB_W +: ROB_W]),
                    DATA_W'(q[c][0].rob));
                chk($sformatf("data[%0d]", c), bus.xbar_rtn_data_o[c*DATA_W +: DATA_W],
                    q[c][0].data);
            end
        end
        chk("rob_err", DATA_W'(err), DATA_W'(m_err));
    endfunction

    // Advance one clock and apply the same edge to the model.
    task automatic tick();
        bit                r;
        bit                acc;
        int                ch;
        logic [CH_NUM-1:0] pop;
        ent_t              e;
        r   = rst;
        ch  = int'(bus.sc_xbar_channel_id_i);
        acc = bus.sc_xbar_valid_i && (q[ch].size() < DEPTH);
        e   = '{rob: bus.sc_xbar_rob_num_i, data: bus.sc_xbar_data_i};
        for (int c = 0; c < CH_NUM; c++) pop[c] = (q[c].size() != 0) && bus.xbar_rtn_ready_i[c];
        if (!r && bus.xbar_rtn_valid_o[1] && bus.xbar_rtn_ready_i[1])
            ch1_out.push_back(bus.xbar_rtn_rob_num_o[ROB_W +: ROB_W]);
        @(posedge clk);
        if (r) begin
            for (int c = 0; c < CH_NUM; c++) begin
                q[c].delete();
                m_exp[c] = '0;
            end
            m_err    = '0;
            model_ok = 1'b1;
        end else begin
            for (int c = 0; c < CH_NUM; c++) if (pop[c]) void'(q[c].pop_front());
            if (acc) begin
                q[ch].push_back(e);
`ifdef BANK_XBAR_RTN_ROB_CHK_EN
                if (e.rob != m_exp[ch]) m_err[ch] = 1'b1;
                m_exp[ch] = e.rob + ROB_W'(1);
`endif
            end
        end
        #1;
    endtask

    task automatic cyc(input bit v, input int ch, input rob_num_t rob,
                       input logic [DATA_W-1:0] d, input logic [CH_NUM-1:0] rdy);
        drive(1'b0, v, ch, rob, d, rdy);
        #1;
        check_model();
        tick();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit               v;
        int               ch;
        rob_num_t         rob;
        logic [7:0]       db;
        logic [CH_NUM-1:0] rdy;
        bit               exp_sc;
        logic [CH_NUM-1:0] exp_vld;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [DATA_W-1:0] d;
        logic [7:0]        b;
        int                idx;
        int                t;
        bit                acc;

        tbl[0]  = '{1, 2, 5, 8'hA5, 4'b1111, 1, 4'b0000};
        tbl[1]  = '{0, 0, 0, 8'h00, 4'b1111, 1, 4'b0100};
        tbl[2]  = '{0, 0, 0, 8'h00, 4'b1111, 1, 4'b0000};
        tbl[3]  = '{1, 0, 0, 8'hB0, 4'b1110, 1, 4'b0000};
        tbl[4]  = '{1, 0, 1, 8'hB1, 4'b1110, 1, 4'b0001};
        tbl[5]  = '{1, 0, 2, 8'hB2, 4'b1110, 0, 4'b0001};
        tbl[6]  = '{1, 1, 0, 8'hC0, 4'b1110, 1, 4'b0001};
        tbl[7]  = '{1, 1, 1, 8'hC1, 4'b1110, 1, 4'b0011};
        tbl[8]  = '{1, 1, 2, 8'hC2, 4'b1110, 1, 4'b0011};
        tbl[9]  = '{0, 0, 0, 8'h00, 4'b1110, 0, 4'b0011};
        tbl[10] = '{0, 1, 0, 8'h00, 4'b1110, 1, 4'b0001};
        tbl[11] = '{0, 1, 0, 8'h00, 4'b1111, 1, 4'b0001};
        tbl[12] = '{0, 1, 0, 8'h00, 4'b1111, 1, 4'b0001};
        tbl[13] = '{0, 1, 0, 8'h00, 4'b1111, 1, 4'b0000};

        // reset
        drive(1'b1, 1'b0, 0, '0, '0, '0);
        tick();
        tick();
        drive(1'b0, 1'b0, 0, '0, '0, '0);
        #1;
        chk("rst_valid", DATA_W'(bus.xbar_rtn_valid_o), '0);
        chk("rst_cnt", DATA_W'(cnt), '0);
        chk("rst_err", DATA_W'(err), '0);
        chk("rst_sc_ready", DATA_W'(bus.sc_xbar_ready_o), DATA_W'(1));
        tick();

        // single beat + head-of-line isolation
        for (int i = 0; i < 14; i++) begin
            b = tbl[i].db;
            d = {16{b}};
            drive(1'b0, tbl[i].v, tbl[i].ch, tbl[i].rob, d, tbl[i].rdy);
            #1;
            check_model();
            chk($sformatf("tbl%0d_sc_ready", i), DATA_W'(bus.sc_xbar_ready_o), DATA_W'(tbl[i].exp_sc));
            chk($sformatf("tbl%0d_valid", i), DATA_W'(bus.xbar_rtn_valid_o), DATA_W'(tbl[i].exp_vld));
            if (i == 1) begin
                chk("single_rob", DATA_W'(bus.xbar_rtn_rob_num_o[2*ROB_W +: ROB_W]), DATA_W'(5));
                chk("single_data", bus.xbar_rtn_data_o[2*DATA_W +: DATA_W], {16{8'hA5}});
            end
            if (i == 8) begin
                chk("hol_ch0_cnt", DATA_W'(cnt[0 +: CW]), DATA_W'(2));
                chk("hol_ch0_rob", DATA_W'(bus.xbar_rtn_rob_num_o[0 +: ROB_W]), DATA_W'(0));
            end
            tick();
        end

        // full boundary with same-cycle pop on ch3
        cyc(1'b1, 3, 3'd0, {4{32'h3000_0000}}, 4'b0111);
        cyc(1'b1, 3, 3'd1, {4{32'h3000_0001}}, 4'b0111);
        drive(1'b0, 1'b1, 3, 3'd2, {4{32'h3000_0002}}, 4'b1111);
        #1;
        check_model();
        chk("full_no_passthru", DATA_W'(bus.sc_xbar_ready_o), '0);
        chk("full_head_rob0", DATA_W'(bus.xbar_rtn_rob_num_o[3*ROB_W +: ROB_W]), DATA_W'(0));
        tick();
        #1;
        check_model();
        chk("full_ready_after_pop", DATA_W'(bus.sc_xbar_ready_o), DATA_W'(1));
        chk("full_head_rob1", DATA_W'(bus.xbar_rtn_rob_num_o[3*ROB_W +: ROB_W]), DATA_W'(1));
        tick();
        drive(1'b0, 1'b0, 3, '0, '0, 4'b1111);
        #1;
        chk("full_head_rob2", DATA_W'(bus.xbar_rtn_rob_num_o[3*ROB_W +: ROB_W]), DATA_W'(2));
        for (int i = 0; i < 3; i++) cyc(1'b0, 3, '0, '0, 4'b1111);

        // wrap-around on ch1, ready toggling 1010
        ch1_out.delete();
        idx = 0;
        t   = 0;
        while (idx < 10 && t < 40) begin
            drive(1'b0, 1'b1, 1, rob_num_t'(idx % 8), {$urandom, $urandom, $urandom, $urandom},
                  (t % 2 == 0) ? 4'b0010 : 4'b0000);
            #1;
            check_model();
            chk("wrap_cnt_le_depth", DATA_W'(cnt[CW +: CW] <= CW'(DEPTH)), DATA_W'(1));
            acc = (q[1].size() < DEPTH);
            tick();
            if (acc) idx++;
            t++;
        end
        chk("wrap_all_accepted", DATA_W'(idx), DATA_W'(10));
        for (int i = 0; i < 5; i++) cyc(1'b0, 0, '0, '0, 4'b1111);
        chk("wrap_out_count", DATA_W'(ch1_out.size()), DATA_W'(10));
        for (int i = 0; i < ch1_out.size() && i < 10; i++)
            chk($sformatf("wrap_order%0d", i), DATA_W'(ch1_out[i]), DATA_W'(i % 8));

        // reset mid-operation
        cyc(1'b1, 0, 3'd0, {4{32'hA0}}, 4'b0000);
        cyc(1'b1, 0, 3'd1, {4{32'hA1}}, 4'b0000);
        cyc(1'b1, 2, 3'd0, {4{32'hA2}}, 4'b0000);
        cyc(1'b1, 2, 3'd1, {4{32'hA3}}, 4'b0000);
        chk("pre_rst_cnt", DATA_W'(cnt), DATA_W'(8'b0010_0010));
        drive(1'b1, 1'b1, 1, 3'd5, {4{32'hDEAD}}, 4'b0000);
        #1;
        tick();
        drive(1'b0, 1'b0, 0, '0, '0, 4'b1111);
        #1;
        chk("midrst_valid", DATA_W'(bus.xbar_rtn_valid_o), '0);
        chk("midrst_cnt", DATA_W'(cnt), '0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 0, '0, '0, 4'b1111);

        // ROB order checker on ch2: 0,1,3
        cyc(1'b1, 2, 3'd0, '0, 4'b1111);
        cyc(1'b1, 2, 3'd1, '0, 4'b1111);
        drive(1'b0, 1'b0, 2, '0, '0, 4'b1111);
        #1;
        chk("rob_ok_before", DATA_W'(err), '0);
        cyc(1'b1, 2, 3'd3, '0, 4'b1111);
        cyc(1'b0, 0, '0, '0, 4'b1111);
        cyc(1'b1, 2, 3'd4, '0, 4'b1111);
        cyc(1'b0, 0, '0, '0, 4'b1111);
`ifdef BANK_XBAR_RTN_ROB_CHK_EN
        chk("rob_err_sticky", DATA_W'(err), DATA_W'(4'b0100));
`else
        chk("rob_err_tied", DATA_W'(err), '0);
`endif

        // randomized traffic against the model
        drive(1'b1, 1'b0, 0, '0, '0, '0);
        tick();
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 4) != 0, int'($urandom % CH_NUM), rob_num_t'($urandom),
                {$urandom, $urandom, $urandom, $urandom}, CH_NUM'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
